adder_8_bits: RTL and testbench

- Registered 8-bit two's-complement adder with a signed-overflow flag and an unsigned carry-out.
- Sits in the datapath as a one-cycle-latency arithmetic primitive.
- Consumers sample sum/ovf the cycle after operands are presented.
- Vector bit 1 is the MSB (sign) and bit WIDTH is the LSB on all data ports.

---
 rtl/adder_8_bits.sv | 70 +++++++
 tb/tb_adder_8_bits.sv | 117 +++++++++++
 2 files changed

// File: rtl/adder_8_bits.sv
// adder_8_bits: registered WIDTH-bit two's-complement ripple-carry adder.
// Ports: clk, rst_n (sync, active low), x/y operands [1:WIDTH] (bit 1 = MSB),
//   sum [1:WIDTH] registered result, ovf signed overflow, cout unsigned carry.
// Optional: define ADDER_SAT_EN for signed saturation of sum on overflow.
module adder_8_bits #(
   parameter int WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [1:WIDTH] x,
   input  logic [1:WIDTH] y,
   output logic [1:WIDTH] sum,
   output logic           ovf,
   output logic           cout
);

   // carry[i+1] feeds cell i; carry[WIDTH+1] is the chain's carry-in.
   logic [1:WIDTH+1] carry;
   logic [1:WIDTH]   raw_sum;
   logic             raw_ovf;

   logic [1:WIDTH]   sum_d, sum_q;
   logic             ovf_d, ovf_q;
   logic             cout_d, cout_q;

   assign carry[WIDTH+1] = 1'b0;

   for (genvar i = 1; i <= WIDTH; i++) begin : g_fa
      assign raw_sum[i] = x[i] ^ y[i] ^ carry[i+1];
      assign carry[i]   = (x[i] & y[i])
                        | (carry[i+1] & (x[i] ^ y[i]));
   end

   // carry into the MSB cell vs carry out of it
   assign raw_ovf = carry[1] ^ carry[2];

`ifdef ADDER_SAT_EN
   localparam logic [1:WIDTH] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [1:WIDTH] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

   always_comb begin
      sum_d  = raw_sum;
      ovf_d  = raw_ovf;
      cout_d = carry[1];
`ifdef ADDER_SAT_EN
      // on overflow both operands share x's sign; clamp toward it
      if (raw_ovf) begin
         sum_d = x[1] ? SAT_MIN : SAT_MAX;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sum_q  <= '0;
         ovf_q  <= 1'b0;
         cout_q <= 1'b0;
      end else begin
         sum_q  <= sum_d;
         ovf_q  <= ovf_d;
         cout_q <= cout_d;
      end
   end

   assign sum  = sum_q;
   assign ovf  = ovf_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_adder_8_bits.sv
// tb_adder_8_bits: directed + random scoreboard bench for adder_8_bits.
// Expected results queued at drive time, popped one edge later.
module tb_adder_8_bits;

   typedef struct packed {
      logic [7:0] s;
      logic       o;
      logic       c;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] x = '0;
   logic [7:0] y = '0;
   logic [7:0] sum;
   logic       ovf;
   logic       cout;

   int checks = 0;
   int failures = 0;
   exp_t exp_q[$];

   adder_8_bits #(.WIDTH(8)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .x    (x),
      .y    (y),
      .sum  (sum),
      .ovf  (ovf),
      .cout (cout)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [7:0] a,
                                  input logic [7:0] b,
                                  input logic r);
      exp_t e;
      int   u;
      int   sa, sb, ss;
      if (!r) begin
         e = '0;
         return e;
      end
      u  = int'(a) + int'(b);
      sa = a[7] ? int'(a) - 256 : int'(a);
      sb = b[7] ? int'(b) - 256 : int'(b);
      ss = sa + sb;
      e.s = u[7:0];
      e.c = (u > 255);
      e.o = (ss > 127) || (ss < -128);
`ifdef ADDER_SAT_EN
      if (e.o) e.s = (ss > 127) ? 8'h7F : 8'h80;
`endif
      return e;
   endfunction

   task automatic check(input string tag,
                        input logic [7:0] got,
                        input logic [7:0] want);
      checks++;
      assert (got === want) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, got, want);
      end
   endtask

   task automatic step(input string tag,
                       input logic [7:0] a,
                       input logic [7:0] b,
                       input logic r);
      exp_t e;
      @(negedge clk);
      x = a;
      y = b;
      rst_n = r;
      exp_q.push_back(model(a, b, r));
      @(posedge clk);
      #1;
      checks++;
      assert (exp_q.size() != 0) else begin
         failures++;
         $error("FAIL %s_queue: observed empty expected entry", tag);
      end
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check({tag, "_sum"}, sum, e.s);
         check({tag, "_ovf"}, {7'b0, ovf}, {7'b0, e.o});
         check({tag, "_cout"}, {7'b0, cout}, {7'b0, e.c});
      end
   endtask

   initial begin
      step("rst0", 8'hAA, 8'h55, 1'b0);
      step("rst1", 8'hAA, 8'h55, 1'b0);
      step("rel", 8'hAA, 8'h55, 1'b1);
      step("z00", 8'h00, 8'h00, 1'b1);
      step("a10", 8'h01, 8'h00, 1'b1);
      step("a11", 8'h01, 8'h01, 1'b1);
      step("pos_ovf", 8'h7F, 8'h01, 1'b1);
      step("neg_ovf", 8'h80, 8'h80, 1'b1);
      step("uwrap", 8'hFF, 8'h01, 1'b1);
      step("c0c0", 8'hC0, 8'hC0, 1'b1);
      step("neg_edge", 8'h80, 8'hFF, 1'b1);
      step("pos_edge", 8'h40, 8'h40, 1'b1);
      step("max_fit", 8'h7E, 8'h01, 1'b1);
      for (int i = 0; i < 256; i++) begin
         step((i == 100) ? "mid_rst" : "rnd",
              8'($urandom_range(255)),
              8'($urandom_range(255)),
              (i != 100));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
